// File: rtl/dmem_responder.sv
// Single-port data memory responder with a fixed request-to-response latency.
// Optional macro DMEM_MISALIGN_CHECK_EN turns misaligned accesses into error responses.
`timescale 1ns/1ps
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [2:0] CNT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [2:0]    r_cnt;
   logic [AW-1:0] r_idx;
   logic          r_write;
   logic [31:0]   r_wdata;
   logic [3:0]    r_wstrb;
   logic          r_misalign;
   logic [31:0]   r_rdata;
   logic          r_err;
   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          w_accept;
   logic          w_enter_resp;
   logic          w_addr_misalign;
   logic [AW-1:0] w_idx;
   logic          w_write;
   logic [31:0]   w_wdata;
   logic [3:0]    w_wstrb;
   logic          w_misalign;
   logic          w_mem_we;
   logic [31:0]   w_old_word;
   logic [31:0]   w_merged;
   logic          w_unused;

   assign w_accept = req_valid && (r_state == S_IDLE);

`ifdef DMEM_MISALIGN_CHECK_EN
   assign w_addr_misalign = (req_addr[1:0] != 2'b00);
`else
   assign w_addr_misalign = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_cnt == 3'd0) begin
               w_state_next = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // With LATENCY=1 the access happens on the accepting edge, before the
   // request registers hold anything, so take the operands straight from the port.
   assign w_idx        = (r_state == S_IDLE) ? req_addr[AW+1:2] : r_idx;
   assign w_write      = (r_state == S_IDLE) ? req_write       : r_write;
   assign w_wdata      = (r_state == S_IDLE) ? req_wdata       : r_wdata;
   assign w_wstrb      = (r_state == S_IDLE) ? req_wstrb       : r_wstrb;
   assign w_misalign   = (r_state == S_IDLE) ? w_addr_misalign : r_misalign;
   assign w_enter_resp = (w_state_next == S_RESP) && (r_state != S_RESP);
   assign w_mem_we     = w_enter_resp && w_write && !w_misalign;
   assign w_old_word   = r_mem[w_idx];

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_merged[8*gi +: 8] = w_wstrb[gi] ? w_wdata[8*gi +: 8] : w_old_word[8*gi +: 8];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt      <= 3'd0;
         r_idx      <= '0;
         r_write    <= 1'b0;
         r_wdata    <= 32'd0;
         r_wstrb    <= 4'd0;
         r_misalign <= 1'b0;
         r_rdata    <= 32'd0;
         r_err      <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cnt      <= CNT_LOAD;
            r_idx      <= req_addr[AW+1:2];
            r_write    <= req_write;
            r_wdata    <= req_wdata;
            r_wstrb    <= req_wstrb;
            r_misalign <= w_addr_misalign;
         end else if ((r_state == S_WAIT) && (r_cnt != 3'd0)) begin
            r_cnt <= r_cnt - 3'd1;
         end
         if (w_enter_resp) begin
            r_rdata <= (w_write || w_misalign) ? 32'd0 : w_old_word;
            r_err   <= w_misalign;
         end
      end
   end

   // Memory is a register array because reset must clear every word.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            r_mem[i] <= 32'd0;
         end
      end else if (w_mem_we) begin
         r_mem[w_idx] <= w_merged;
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_rdata = rsp_valid ? r_rdata : 32'd0;

`ifdef DMEM_MISALIGN_CHECK_EN
   assign rsp_err = rsp_valid && r_err;
`else
   assign rsp_err = 1'b0;
`endif

   assign w_unused = &{1'b0, req_addr[31:AW+2], req_addr[1:0], r_misalign, r_err};

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed vector table, hand-written reset/misalign
// sequences, then randomized transactions against a byte-lane memory model.
`timescale 1ns/1ps
module tb_dmem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] model_mem [DEPTH];

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          hold;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference: memory as a word array, stores merge selected bytes.
   function automatic void model_apply(input logic wr, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] strb,
                                       output logic [31:0] rd, output logic err);
      int  idx;
      logic misal;
      idx = int'(addr[9:2]);
`ifdef DMEM_MISALIGN_CHECK_EN
      misal = (addr[1:0] != 2'b00);
`else
      misal = 1'b0;
`endif
      rd  = 32'd0;
      err = misal;
      if (!misal) begin
         if (wr) begin
            for (int b = 0; b < 4; b++) begin
               if (strb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
         end else begin
            rd = model_mem[idx];
         end
      end
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
   endtask

   task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                          input logic [31:0] exp_rdata, input logic exp_err);
      int          cyc;
      logic [31:0] held;
      check({tag, " req_ready before"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = strb;
      tick();
      // scramble inputs: the captured request must not follow them
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
      check({tag, " busy after accept"}, 32'(busy), 32'd1);
      check({tag, " req_ready after accept"}, 32'(req_ready), 32'd0);
      cyc = 1;
      while (!rsp_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      if (!rsp_valid) begin
         check({tag, " response timeout"}, 32'(rsp_valid), 32'd1);
         return;
      end
      check({tag, " latency"}, 32'(cyc), 32'(LAT));
      check({tag, " rdata"}, rsp_rdata, exp_rdata);
      check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
      held = rsp_rdata;
      repeat (hold) begin
         tick();
         check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
         check({tag, " hold rdata"}, rsp_rdata, held);
         check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      end
      // offer a competing request during the handshake; it must be refused
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b0;
      tick();
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      check({tag, " rsp_valid after handshake"}, 32'(rsp_valid), 32'd0);
      check({tag, " rdata after handshake"}, rsp_rdata, 32'd0);
      check({tag, " req_ready after handshake"}, 32'(req_ready), 32'd1);
      check({tag, " busy after handshake"}, 32'(busy), 32'd0);
      $display("[TB] %s wr=%0d addr=%08h wdata=%08h strb=%h rdata=%08h err=%0d lat=%0d",
               tag, wr, addr, wdata, strb, held, exp_err, cyc);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] e_rd;
      logic        e_err;
      logic        r_wr;
      logic [31:0] r_addr;
      logic [31:0] r_wdata;
      logic [3:0]  r_strb;

      vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF,    0, 32'h0000_0000, 1'b0};
      vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0,    0, 32'hDEAD_BEEF, 1'b0};
      vecs[2] = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'hF,    0, 32'h0000_0000, 1'b0};
      vecs[3] = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0101, 1, 32'h0000_0000, 1'b0};
      vecs[4] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0,    5, 32'hAA22_CC44, 1'b0};
      vecs[5] = '{1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF,    0, 32'h0000_0000, 1'b0};
      vecs[6] = '{1'b0, 32'h0000_0404, 32'h0000_0000, 4'h0,    2, 32'h1234_5678, 1'b0};
      vecs[7] = '{1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'h0,    0, 32'h0000_0000, 1'b0};
      vecs[8] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'h0,    0, 32'h0000_0000, 1'b0};

      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      req_wstrb = 4'd0;
      rsp_ready = 1'b0;
      reset     = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      model_clear();
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_rdata", rsp_rdata, 32'd0);
      check("reset rsp_err", 32'(rsp_err), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset req_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 9; i++) begin
         run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].strb, vecs[i].hold, vecs[i].exp_rdata, vecs[i].exp_err);
      end

      // store aborted by reset during its WAIT cycle
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0000_0030;
      req_wdata = 32'hCAFE_F00D;
      req_wstrb = 4'hF;
      tick();
      req_valid = 1'b0;
      reset     = 1'b1;
      tick();
      reset = 1'b0;
      model_clear();
      check("abort rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort req_ready", 32'(req_ready), 32'd1);
      check("abort busy", 32'(busy), 32'd0);
      repeat (2) begin
         tick();
         check("abort no late response", 32'(rsp_valid), 32'd0);
      end
      run_txn("abort_load", 1'b0, 32'h0000_0030, 32'd0, 4'h0, 0, 32'h0000_0000, 1'b0);
      run_txn("cleared_load", 1'b0, 32'h0000_0010, 32'd0, 4'h0, 0, 32'h0000_0000, 1'b0);

`ifdef DMEM_MISALIGN_CHECK_EN
      run_txn("misalign_st", 1'b1, 32'h0000_0041, 32'hFFFF_FFFF, 4'hF, 0, 32'h0000_0000, 1'b1);
      run_txn("misalign_ld", 1'b0, 32'h0000_0040, 32'd0, 4'h0, 0, 32'h0000_0000, 1'b0);
`else
      run_txn("lowbits_st", 1'b1, 32'h0000_0041, 32'hFFFF_FFFF, 4'hF, 0, 32'h0000_0000, 1'b0);
      run_txn("lowbits_ld", 1'b0, 32'h0000_0040, 32'd0, 4'h0, 0, 32'hFFFF_FFFF, 1'b0);
`endif
      model_apply(1'b1, 32'h0000_0041, 32'hFFFF_FFFF, 4'hF, e_rd, e_err);

      for (int i = 0; i < 300; i++) begin
         r_wr    = 1'($urandom_range(0, 1));
         r_addr  = $urandom;
         r_addr[9:6] = 4'd0;
         if ($urandom_range(0, 7) != 0) r_addr[1:0] = 2'b00;
         r_wdata = $urandom;
         r_strb  = 4'($urandom);
         model_apply(r_wr, r_addr, r_wdata, r_strb, e_rd, e_err);
         run_txn($sformatf("rnd%0d", i), r_wr, r_addr, r_wdata, r_strb,
                 int'($urandom_range(0, 2)), e_rd, e_err);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
